// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the mm:ss countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;
  localparam digit_t SEC_T_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD down-counting digit with clamped load and borrow chain
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter digit_t MAX = DIGIT_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  digit_t load_val,
  input  logic   borrow_in,
  output digit_t digit,
  output logic   borrow_out
);

  // Out-of-range preset digits saturate to the digit's maximum.
  digit_t clamped;
  assign clamped    = (load_val > MAX) ? MAX : load_val;
  assign borrow_out = borrow_in && (digit == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= clamped;
    end else if (borrow_in) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// rtl/timer_countdown.sv - four-digit BCD mm:ss countdown with 1 s prescaler and run/pause FSM
module timer_countdown
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   start,
  input  logic   pause,
  input  digit_t set_min_t,
  input  digit_t set_min_u,
  input  digit_t set_sec_t,
  input  digit_t set_sec_u,
  output digit_t min_t,
  output digit_t min_u,
  output digit_t sec_t,
  output digit_t sec_u,
  output logic   running,
  output logic   tick,
  output logic   done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          is_zero;
  logic          is_one;
  logic          advance;
  logic          wrap;
  logic          b_su;
  logic          b_st;
  logic          b_mu;
  logic          b_mt;

  assign is_zero = ({min_t, min_u, sec_t, sec_u} == 16'h0000);
  assign is_one  = ({min_t, min_u, sec_t, sec_u} == 16'h0001);

  // The resume edge counts as a running cycle, returning the one the pause edge froze.
  assign advance = !load && ((state == RUN && !pause) || (state == PAUSE && start));
  assign wrap    = advance && (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else if (state == IDLE && start && !is_zero) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (state == RUN && pause) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else if (advance) begin
        state   <= RUN;
        running <= 1'b1;
        if (wrap) begin
          presc <= '0;
          tick  <= 1'b1;
          if (is_one) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_u (
    .clk(clk), .rst(rst), .load(load), .load_val(set_sec_u),
    .borrow_in(wrap), .digit(sec_u), .borrow_out(b_su)
  );

  bcd_digit_down #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .load(load), .load_val(set_sec_t),
    .borrow_in(b_su), .digit(sec_t), .borrow_out(b_st)
  );

  bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_u (
    .clk(clk), .rst(rst), .load(load), .load_val(set_min_u),
    .borrow_in(b_st), .digit(min_u), .borrow_out(b_mu)
  );

  // 00:00 is never decremented, so min_t never needs to wrap; its borrow is unused.
  bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_t (
    .clk(clk), .rst(rst), .load(load), .load_val(set_min_t),
    .borrow_in(b_mu), .digit(min_t), .borrow_out(b_mt)
  );

  logic unused_ok;
  assign unused_ok = b_mt;

endmodule

// File: tb/tb_timer_countdown.sv
// tb/tb_timer_countdown.sv - directed self-checking bench for timer_countdown with TICK_DIV=4
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] set_min_t = 4'd0;
  logic [3:0] set_min_u = 4'd0;
  logic [3:0] set_sec_t = 4'd0;
  logic [3:0] set_sec_u = 4'd0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       running, tick, done;

  int checks = 0;
  int errors = 0;
  logic seen_tick;
  logic seen_done;

  timer_countdown #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
    .set_min_t(set_min_t), .set_min_u(set_min_u),
    .set_sec_t(set_sec_t), .set_sec_u(set_sec_u),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .running(running), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    {set_min_t, set_min_u, set_sec_t, set_sec_u} = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_digits", 32'(digits()), 32'h0000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    cyc(1);

    // clamp: all-0xF loads as 99:59
    do_load(16'hFFFF);
    chk("clamp", 32'(digits()), 32'h9959);
    chk("clamp_running", 32'(running), 32'd0);

    // load with start in the same cycle: load wins
    {set_min_t, set_min_u, set_sec_t, set_sec_u} = 16'h1234;
    load = 1'b1;
    start = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b0;
    chk("ld_start_digits", 32'(digits()), 32'h1234);
    chk("ld_start_running", 32'(running), 32'd0);
    cyc(1);
    chk("ld_start_idle", 32'(running), 32'd0);

    // reset mid-run
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("run_running", 32'(running), 32'd1);
    cyc(9);
    chk("run_digits", 32'(digits()), 32'h1232);
    rst = 1'b1;
    #1;
    chk("midrst_digits", 32'(digits()), 32'h0000);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    cyc(1);
    rst = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("postrst_start_ign", 32'(running), 32'd0);
    seen_tick = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      seen_tick |= tick;
      seen_done |= done;
    end
    chk("postrst_no_tick", 32'(seen_tick), 32'd0);
    chk("postrst_no_done", 32'(seen_done), 32'd0);
    chk("postrst_digits", 32'(digits()), 32'h0000);

    // borrow chain 01:00 -> 00:59 -> 00:58
    do_load(16'h0100);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("brw_pre", 32'(digits()), 32'h0100);
    chk("brw_pre_tick", 32'(tick), 32'd0);
    cyc(1);
    chk("brw_59", 32'(digits()), 32'h0059);
    chk("brw_59_tick", 32'(tick), 32'd1);
    cyc(1);
    chk("brw_tick_pulse", 32'(tick), 32'd0);
    cyc(3);
    chk("brw_58", 32'(digits()), 32'h0058);
    chk("brw_58_tick", 32'(tick), 32'd1);

    // expiry 00:02 -> 00:01 -> 00:00
    do_load(16'h0002);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    chk("exp_01", 32'(digits()), 32'h0001);
    chk("exp_01_done", 32'(done), 32'd0);
    cyc(4);
    chk("exp_00", 32'(digits()), 32'h0000);
    chk("exp_tick", 32'(tick), 32'd1);
    chk("exp_done", 32'(done), 32'd1);
    chk("exp_running", 32'(running), 32'd0);
    cyc(1);
    chk("exp_done_pulse", 32'(done), 32'd0);
    seen_tick = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen_tick |= tick;
      seen_done |= done;
    end
    chk("exp_no_tick", 32'(seen_tick), 32'd0);
    chk("exp_no_done", 32'(seen_done), 32'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("exp_start_ign", 32'(running), 32'd0);
    chk("exp_hold", 32'(digits()), 32'h0000);

    // pause at prescaler 2, resume
    do_load(16'h0010);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("pause_running", 32'(running), 32'd0);
    seen_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      seen_tick |= tick;
    end
    chk("pause_digits", 32'(digits()), 32'h0010);
    chk("pause_no_tick", 32'(seen_tick), 32'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_edge_digits", 32'(digits()), 32'h0010);
    cyc(1);
    chk("resume_09", 32'(digits()), 32'h0009);
    chk("resume_tick", 32'(tick), 32'd1);

    // load during RUN on the wrap cycle
    do_load(16'h0010);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    {set_min_t, set_min_u, set_sec_t, set_sec_u} = 16'h0030;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("ldwrap_digits", 32'(digits()), 32'h0030);
    chk("ldwrap_tick", 32'(tick), 32'd0);
    chk("ldwrap_running", 32'(running), 32'd0);
    cyc(5);
    chk("ldwrap_idle", 32'(digits()), 32'h0030);

    // start ignored with count 00:00
    do_load(16'h0000);
    start = 1'b1;
    cyc(1);
    chk("zero_start_running", 32'(running), 32'd0);
    cyc(4);
    start = 1'b0;
    chk("zero_start_tick", 32'(tick), 32'd0);
    chk("zero_start_digits", 32'(digits()), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
# timer_countdown

Four-digit BCD mm:ss countdown core for the timer datapath. It divides the system clock down to a 1 s tick and decrements a loadable minutes:seconds value. It also flags expiry. Each 4-bit digit output feeds a downstream 4-bit 2:1 digit selector, which picks between the preset value and the running count for display.

## Interface
- TICK_DIV, 100_000_000: clk cycles per count step (one second); legal range ≥ 2.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  level-sampled; copies set_* digits into count.
- start  in  1  level-sampled; begin or resume counting.
- pause  in  1  level-sampled; freeze counting.
- set_min_t  in  4  preset minutes tens, BCD.
- set_min_u  in  4  preset minutes units, BCD.
- set_sec_t  in  4  preset seconds tens, BCD.
- set_sec_u  in  4  preset seconds units, BCD.
- min_t  out  4  count minutes tens.
- min_u  out  4  count minutes units.
- sec_t  out  4  count seconds tens.
- sec_u  out  4  count seconds units.
- running  out  1  high while in RUN.
- tick  out  1  one-cycle pulse on each count step.
- done  out  1  one-cycle pulse when count reaches 00:00.

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSE: frozen.
  - DONE: expired.
- Input priority per cycle is load > start > pause.
- load, any state:
  - count takes the clamped set_* value; state goes to IDLE; prescaler clears to 0.
  - Clamp rule: a digit > 9 loads as 9; set_sec_t > 5 loads as 5. Example: all-0xF loads as 99:59.
- start:
  - In IDLE or PAUSE with count ≠ 00:00, state goes to RUN.
  - Ignored in RUN, in DONE, or when count = 00:00.
- pause:
  - In RUN, state goes to PAUSE; prescaler holds its value.
  - Ignored in all other states.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - At TICK_DIV-1 it wraps to 0, tick pulses, and count decrements by one second.
  - Width is $clog2(TICK_DIV).
- Decrement chain:
  - sec_u steps 0→9 with a borrow; sec_t steps 0→5 with a borrow; min_u steps 0→9 with a borrow; min_t decrements.
  - 00:00 is never decremented; the count does not wrap to 99:59.
- Expiry:
  - On the step 00:01→00:00, state goes to DONE and done pulses.
  - In DONE, count stays 00:00 and the prescaler stays 0. Only load leaves DONE.

## Timing
- Reset values: all digits 0, state IDLE, prescaler 0, running 0, tick 0, done 0.
- rst asserted mid-run forces the reset values immediately; there is no pending tick or done after release.
- All outputs are registered. Digits change only on the edge where the prescaler wraps, or the edge that samples load.
- running rises on the edge that samples start.
- The first decrement is visible TICK_DIV cycles after the start edge.
- tick is high in the same cycle the new digits first appear.
- done is high in the same cycle that 00:00 first appears. running is 0 in that cycle.
- Resume after pause: the next step comes TICK_DIV − (held prescaler value) − 1 cycles after the start edge, so no partial second is lost.
- load on the cycle the prescaler would wrap: load wins, and no tick or decrement occurs.

## Structure
- The shared package timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the 4-bit BCD digit typedef;
  - constants DIGIT_MAX = 9 and SEC_T_MAX = 5.
- One sub-module, bcd_digit_down:
  - Parameter MAX; inputs load, load value, borrow_in; outputs digit, borrow_out.
  - Instantiated four times (MAX = 9, 5, 9, 9).
- The FSM and prescaler live in the top level.

## Test plan
All scenarios use TICK_DIV=4.
- Reset mid-run: load 12:34, start, run 10 cycles, assert rst → all digits 0, running 0, no done; start after release ignored (count 00:00).
- Borrow chain: load 01:00, start → 00:59 appears 4 cycles after start with tick high; 00:58 4 cycles later.
- Expiry: load 00:02, start → 00:01 at +4, 00:00 at +8 with done for exactly 1 cycle; no further ticks over 20 cycles; start ignored until load.
- Pause/resume: load 00:10, start, pause when prescaler = 2, hold 10 cycles (digits stable, tick 0), start → 00:09 appears 1 cycle later.
- Clamp and priority:
  - load all-0xF → 99:59.
  - load with start asserted the same cycle → IDLE, running 0.
  - load during RUN at the prescaler wrap → new value, no decrement.
- Ignored start: load 00:00, start → state IDLE, running 0, no tick.
